phase_acc: RTL and testbench

- Phase accumulator / NCO front end that feeds the interpolated sine shaper: produces a 32-bit phase word `phs` and a one-cycle `ena` strobe per sample.
- Supports linear frequency glide (portamento), hard sync, and a static phase offset.
- Sits between the sample-rate tick generator and the waveshaper.
- Also exports a wrap pulse for chaining hard sync into other oscillators.

---
 rtl/phase_acc.sv | 157 +++++++++++++++
 tb/tb_phase_acc.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_acc.sv
// Phase accumulator / NCO front end.
// A sample tick walks a three-stage pipeline: GLIDE slews the working
// increment toward the target frequency, ACCUM advances (or hard-syncs) the
// phase accumulator, and OUT presents the offset phase with a one-cycle
// strobe. Ticks that arrive while GLIDE or ACCUM are occupied are dropped
// and flagged through the sticky overrun output.
// The glide input is zero-extended into 33-bit arithmetic, so GLIDE_W must
// not exceed 32.

module phase_acc #(
  parameter int GLIDE_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic [31:0]        freq,
  input  logic [GLIDE_W-1:0] glide,
  input  logic               sync_in,
  input  logic [31:0]        phs_ofs,
  output logic [31:0]        phs,
  output logic               ena,
  output logic               wrap,
  output logic [31:0]        inc_cur,
  output logic               overrun
);

  // Pipeline occupancy flags: each marks that its stage acts on the next edge.
  logic        glide_vld;
  logic        accum_vld;
  logic        out_vld;

  logic [31:0] acc;
  logic        wrap_int;
  logic        sync_pend;

  logic        busy;
  logic        tick_accept;

  logic [32:0] glide_ext;
  logic [32:0] freq_ext;
  logic [32:0] up_sum;
  logic [32:0] dn_diff;
  logic [31:0] inc_next;
  logic [32:0] acc_sum;

  // A new tick may enter only while GLIDE and ACCUM are both idle; the OUT
  // stage never blocks because it finishes on the same edge that GLIDE starts.
  always_comb begin
    busy        = glide_vld | accum_vld;
    tick_accept = tick & ~busy;
  end

  // Next increment: bounded slew toward freq with 33-bit headroom so the
  // step can neither overflow past 2^32 nor borrow below zero.
  always_comb begin
    glide_ext = {{(33 - GLIDE_W){1'b0}}, glide};
    freq_ext  = {1'b0, freq};
    up_sum    = {1'b0, inc_cur} + glide_ext;
    dn_diff   = {1'b0, inc_cur} - glide_ext;
    inc_next  = inc_cur;
    if (glide == '0) begin
      inc_next = freq;
    end else if (freq > inc_cur) begin
      if (up_sum > freq_ext) begin
        inc_next = freq;
      end else begin
        inc_next = up_sum[31:0];
      end
    end else if (freq < inc_cur) begin
      if (dn_diff[32] || (dn_diff[31:0] < freq)) begin
        inc_next = freq;
      end else begin
        inc_next = dn_diff[31:0];
      end
    end
  end

  // Accumulator sum with the carry kept as the wrap indication.
  always_comb begin
    acc_sum = {1'b0, acc} + {1'b0, inc_cur};
  end

  // Advance the stage flags; reset empties the pipe so no strobe follows.
  always_ff @(posedge clk) begin
    if (reset) begin
      glide_vld <= 1'b0;
      accum_vld <= 1'b0;
      out_vld   <= 1'b0;
    end else begin
      glide_vld <= tick_accept;
      accum_vld <= glide_vld;
      out_vld   <= accum_vld;
    end
  end

  // Sticky record of any tick lost to a busy pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (tick && busy) begin
      overrun <= 1'b1;
    end
  end

  // GLIDE stage: update the working increment once per accepted sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      inc_cur <= '0;
    end else if (glide_vld) begin
      inc_cur <= inc_next;
    end
  end

  // Hard-sync request latch; ACCUM consumes it, so repeated pulses collapse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_pend <= 1'b0;
    end else if (accum_vld) begin
      sync_pend <= 1'b0;
    end else if (sync_in) begin
      sync_pend <= 1'b1;
    end
  end

  // ACCUM stage: restart at zero on sync, otherwise advance and keep the carry.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      wrap_int <= 1'b0;
    end else if (accum_vld) begin
      if (sync_pend || sync_in) begin
        acc      <= '0;
        wrap_int <= 1'b0;
      end else begin
        acc      <= acc_sum[31:0];
        wrap_int <= acc_sum[32];
      end
    end
  end

  // OUT stage: present offset phase with a single-cycle strobe; wrap is
  // qualified so it is never seen outside a strobe cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      phs  <= '0;
      ena  <= 1'b0;
      wrap <= 1'b0;
    end else begin
      ena  <= out_vld;
      wrap <= out_vld & wrap_int;
      if (out_vld) begin
        phs <= acc + phs_ofs;
      end
    end
  end

endmodule

// File: tb/tb_phase_acc.sv
// Directed bench for phase_acc with a reference model feeding a scoreboard.
// Each accepted tick pushes its predicted sample; a monitor pops and compares
// whenever the strobe appears.

module tb_phase_acc;

  localparam int GLIDE_W = 16;

  logic               clk;
  logic               reset;
  logic               tick;
  logic [31:0]        freq;
  logic [GLIDE_W-1:0] glide;
  logic               sync_in;
  logic [31:0]        phs_ofs;
  logic [31:0]        phs;
  logic               ena;
  logic               wrap;
  logic [31:0]        inc_cur;
  logic               overrun;

  typedef struct {
    logic [31:0] phs;
    logic        wrap;
    logic [31:0] inc;
  } sample_t;

  sample_t     sb[$];
  int          nChecks = 0;
  int          nFails  = 0;

  logic [31:0] mAcc;
  logic [31:0] mInc;
  logic        mSync;
  logic [31:0] lastPhs;
  logic        lastWrap;

  phase_acc #(.GLIDE_W(GLIDE_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .freq    (freq),
    .glide   (glide),
    .sync_in (sync_in),
    .phs_ofs (phs_ofs),
    .phs     (phs),
    .ena     (ena),
    .wrap    (wrap),
    .inc_cur (inc_cur),
    .overrun (overrun)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] glideModel(input logic [31:0] cur, input logic [31:0] tgt,
                                             input logic [31:0] g);
    logic [32:0] s;
    if (g == 0) return tgt;
    if (tgt > cur) begin
      s = 33'(cur) + 33'(g);
      return (s > 33'(tgt)) ? tgt : s[31:0];
    end
    if (tgt < cur) begin
      if (g > cur) return tgt;
      if ((cur - g) < tgt) return tgt;
      return cur - g;
    end
    return cur;
  endfunction

  // Predict one sample from the current inputs and queue it.
  task automatic pushSample();
    sample_t     s;
    logic [32:0] sum;
    mInc = glideModel(mInc, freq, 32'(glide));
    if (mSync) begin
      mAcc   = 32'h0;
      s.wrap = 1'b0;
      mSync  = 1'b0;
    end else begin
      sum    = 33'(mAcc) + 33'(mInc);
      mAcc   = sum[31:0];
      s.wrap = sum[32];
    end
    s.phs = mAcc + phs_ofs;
    s.inc = mInc;
    sb.push_back(s);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    tick  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mAcc  = 32'h0;
    mInc  = 32'h0;
    mSync = 1'b0;
    sb.delete();
  endtask

  task automatic pulseSync();
    @(negedge clk);
    sync_in = 1'b1;
    mSync   = 1'b1;
    @(negedge clk);
    sync_in = 1'b0;
  endtask

  // One tick; syncAt 1 = sync with the tick, 2 = sync in the ACCUM cycle.
  // Checks tick-to-strobe latency and leaves a 16-clock sample spacing.
  task automatic applyStimulus(input int syncAt);
    int lat;
    @(negedge clk);
    tick = 1'b1;
    if (syncAt == 1) sync_in = 1'b1;
    if (syncAt != 0) mSync = 1'b1;
    pushSample();
    @(negedge clk);
    tick    = 1'b0;
    sync_in = 1'b0;
    lat     = 0;
    while (!ena && lat < 10) begin
      @(negedge clk);
      lat++;
      sync_in = (syncAt == 2 && lat == 1);
    end
    sync_in  = 1'b0;
    lastPhs  = phs;
    lastWrap = wrap;
    checkOutput("ena_latency", 32'(lat), 32'd3);
    repeat (11) @(negedge clk);
  endtask

  // Scoreboard monitor: every strobe must match the oldest prediction.
  always @(negedge clk) begin
    if (!reset) begin
      if (ena) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_ena", {31'b0, ena}, 32'h0);
        end else begin
          sample_t s;
          s = sb.pop_front();
          checkOutput("sb_phs", phs, s.phs);
          checkOutput("sb_wrap", {31'b0, wrap}, {31'b0, s.wrap});
          checkOutput("sb_inc", inc_cur, s.inc);
        end
      end else begin
        checkOutput("wrap_idle", {31'b0, wrap}, 32'h0);
      end
    end
  end

  logic [31:0] glideExp [8];
  logic [15:0] enaMask;

  initial begin
    reset   = 1'b1;
    tick    = 1'b0;
    freq    = 32'h0;
    glide   = '0;
    sync_in = 1'b0;
    phs_ofs = 32'h0;
    doReset();

    $display("[TB] reset state");
    checkOutput("rst_phs", phs, 32'h0);
    checkOutput("rst_ena", {31'b0, ena}, 32'h0);
    checkOutput("rst_inc", inc_cur, 32'h0);
    checkOutput("rst_overrun", {31'b0, overrun}, 32'h0);

    $display("[TB] linear ramp, 256 samples");
    freq = 32'h0100_0000;
    for (int i = 1; i <= 256; i++) begin
      applyStimulus(0);
      if (i == 1) checkOutput("ramp_first_phs", lastPhs, 32'h0100_0000);
      if (i == 255) checkOutput("ramp_255_wrap", {31'b0, lastWrap}, 32'h0);
    end
    checkOutput("ramp_256_phs", lastPhs, 32'h0);
    checkOutput("ramp_256_wrap", {31'b0, lastWrap}, 32'h1);

    $display("[TB] glide up and down");
    doReset();
    glideExp[0] = 32'h1000; glideExp[1] = 32'h2000; glideExp[2] = 32'h3000; glideExp[3] = 32'h3000;
    glideExp[4] = 32'h2000; glideExp[5] = 32'h1000; glideExp[6] = 32'h0800; glideExp[7] = 32'h0800;
    glide = 16'h1000;
    freq  = 32'h0000_3000;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) freq = 32'h0000_0800;
      applyStimulus(0);
      checkOutput("glide_inc", inc_cur, glideExp[i]);
    end
    glide = '0;

    $display("[TB] hard sync variants");
    doReset();
    freq = 32'h4000_0000;
    applyStimulus(0);
    applyStimulus(0);
    checkOutput("sync_s2_phs", lastPhs, 32'h8000_0000);
    pulseSync();
    pulseSync();
    applyStimulus(0);
    checkOutput("sync_between_phs", lastPhs, 32'h0);
    checkOutput("sync_between_wrap", {31'b0, lastWrap}, 32'h0);
    applyStimulus(0);
    checkOutput("sync_after_phs", lastPhs, 32'h4000_0000);
    applyStimulus(0);
    applyStimulus(1);
    checkOutput("sync_coinc_phs", lastPhs, 32'h0);
    applyStimulus(0);
    applyStimulus(2);
    checkOutput("sync_accum_phs", lastPhs, 32'h0);
    applyStimulus(0);
    checkOutput("sync_accum_next_phs", lastPhs, 32'h4000_0000);

    $display("[TB] static phase offset");
    doReset();
    phs_ofs = 32'h8000_0000;
    freq    = 32'h1000_0000;
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(0);
      if (i == 1) checkOutput("ofs_first_phs", lastPhs, 32'h9000_0000);
      if (i == 15) checkOutput("ofs_15_wrap", {31'b0, lastWrap}, 32'h0);
    end
    checkOutput("ofs_16_phs", lastPhs, 32'h8000_0000);
    checkOutput("ofs_16_wrap", {31'b0, lastWrap}, 32'h1);
    phs_ofs = 32'h0;

    $display("[TB] dropped tick and overrun");
    doReset();
    freq    = 32'h0100_0000;
    enaMask = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      enaMask[c] = ena;
      tick = (c == 0 || c == 2 || c == 3);
      if (c == 0 || c == 3) pushSample();
    end
    tick = 1'b0;
    checkOutput("drop_ena_mask", {16'h0, enaMask}, 32'h0000_0090);
    checkOutput("drop_overrun", {31'b0, overrun}, 32'h1);
    repeat (20) @(negedge clk);
    checkOutput("overrun_sticky", {31'b0, overrun}, 32'h1);
    checkOutput("drop_second_phs", phs, 32'h0200_0000);
    doReset();
    checkOutput("overrun_cleared", {31'b0, overrun}, 32'h0);

    $display("[TB] reset mid-pipeline");
    applyStimulus(0);
    checkOutput("pre_abort_phs", phs, 32'h0100_0000);
    enaMask = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      enaMask[c] = ena;
      tick  = (c == 0);
      reset = (c == 2);
    end
    tick  = 1'b0;
    reset = 1'b0;
    mAcc  = 32'h0;
    mInc  = 32'h0;
    checkOutput("abort_ena_mask", {16'h0, enaMask}, 32'h0);
    checkOutput("abort_phs", phs, 32'h0);
    checkOutput("abort_inc", inc_cur, 32'h0);

    repeat (4) @(negedge clk);
    checkOutput("sb_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
